// File: rtl/tff_pkg.sv
// Shared definitions for the toggle flip-flop bank: mode encodings.
package tff_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_COUNT  = 1'b1;

endpackage

// File: rtl/tff_cell.sv
// Single toggle cell with parallel load; q and q_bar are separate registers
// updated on the same edge so q_bar is never a combinational inversion.
module tff_cell #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic d,
    input  logic toggle,
    output logic q,
    output logic q_bar
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q     <= RESET_VAL;
            q_bar <= ~RESET_VAL;
        end else if (load) begin
            q     <= d;
            q_bar <= ~d;
        end else if (toggle) begin
            q     <= ~q;
            q_bar <= q;
        end
    end

endmodule

// File: rtl/tff_bank.sv
// Bank of WIDTH toggle cells usable as independent T flip-flops or as a binary
// counter. Define TFF_BANK_UPDOWN_EN to add the dir port (down counting).
module tff_bank
    import tff_pkg::*;
#(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
`ifdef TFF_BANK_UPDOWN_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc
);

    logic             count_up;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] terminal;

`ifdef TFF_BANK_UPDOWN_EN
    assign count_up = dir;
`else
    assign count_up = 1'b1;
`endif

    // carry[i]: all lower bits sit at the value that makes bit i flip
    // (all ones counting up, all zeros counting down).
    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            carry[i] = carry[i-1] & (count_up ? q[i-1] : ~q[i-1]);
        end
    end

    always_comb begin
        toggle = '0;
        if (en) begin
            if (mode == MODE_TOGGLE) begin
                toggle = t;
            end else if (t[0]) begin
                toggle = carry;
            end
        end
    end

    assign terminal = count_up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    assign tc = (mode == MODE_COUNT) && en && t[0] && !load && (q == terminal);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell #(
            .RESET_VAL(RESET_VAL[i])
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .load  (load),
            .d     (d[i]),
            .toggle(toggle[i]),
            .q     (q[i]),
            .q_bar (q_bar[i])
        );
    end

endmodule

// File: tb/tb_tff_bank.sv
// Directed self-checking bench for tff_bank at WIDTH=4; the down-count and
// non-zero reset value checks build only with TFF_BANK_UPDOWN_EN.
module tb_tff_bank;
    import tff_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic [3:0] t;
    logic       load;
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] q_bar;
    logic       tc;
    int         total;
    int         bad;
    logic [3:0] exp_q;

`ifdef TFF_BANK_UPDOWN_EN
    logic       dir;
    logic [3:0] q3;
    logic [3:0] q3_bar;
    logic       tc3;
`endif

    tff_bank #(
        .WIDTH    (4),
        .RESET_VAL(4'h0)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .t    (t),
        .load (load),
        .d    (d),
`ifdef TFF_BANK_UPDOWN_EN
        .dir  (dir),
`endif
        .q    (q),
        .q_bar(q_bar),
        .tc   (tc)
    );

`ifdef TFF_BANK_UPDOWN_EN
    tff_bank #(
        .WIDTH    (4),
        .RESET_VAL(4'h3)
    ) dut3 (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .t    (t),
        .load (load),
        .d    (d),
        .dir  (dir),
        .q    (q3),
        .q_bar(q3_bar),
        .tc   (tc3)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        en    = 1'b0;
        mode  = MODE_TOGGLE;
        t     = 4'h0;
        load  = 1'b0;
        d     = 4'h0;
`ifdef TFF_BANK_UPDOWN_EN
        dir   = 1'b1;
`endif
        #12;
        chk("reset_q", q, 4'h0);
        chk("reset_qbar", q_bar, 4'hF);
        chk("reset_tc", {3'b0, tc}, 4'h0);
`ifdef TFF_BANK_UPDOWN_EN
        chk("resetval3_q", q3, 4'h3);
        chk("resetval3_qbar", q3_bar, 4'hC);
`endif

        // Load 0xA, then assert reset mid-cycle.
        rst  = 1'b1;
        step();
        load = 1'b1;
        d    = 4'hA;
        step();
        chk("load_a", q, 4'hA);
        load = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_q", q, 4'h0);
        chk("async_rst_qbar", q_bar, 4'hF);
        rst = 1'b1;
        step();
        chk("post_rst_hold", q, 4'h0);

        // Independent toggling.
        en   = 1'b1;
        mode = MODE_TOGGLE;
        t    = 4'b0101;
        step();
        chk("tog_1", q, 4'h5);
        chk("tog_1_qbar", q_bar, 4'hA);
        step();
        chk("tog_2", q, 4'h0);
        step();
        chk("tog_3", q, 4'h5);
        en = 1'b0;
        step();
        chk("tog_hold_en0", q, 4'h5);
        t = 4'b1010;
        step();
        chk("tog_hold_en0_b", q, 4'h5);

        // Counter from 0: 17 edges, wrap through F -> 0.
        load = 1'b1;
        d    = 4'h0;
        step();
        load = 1'b0;
        mode = MODE_COUNT;
        en   = 1'b1;
        t    = 4'b0001;
        exp_q = 4'h0;
        for (int i = 0; i < 17; i++) begin
            chk("cnt_tc", {3'b0, tc}, {3'b0, (exp_q == 4'hF)});
            step();
            exp_q = exp_q + 4'h1;
            chk("cnt_q", q, exp_q);
            chk("cnt_qbar", q_bar, ~exp_q);
        end

        // t[0]=0 holds the count even with other t bits set.
        t = 4'b1110;
        #1;
        chk("cnt_hold_tc", {3'b0, tc}, 4'h0);
        step();
        chk("cnt_hold_t0", q, 4'h1);

        // Load beats counting; tc drops while load is high.
        load = 1'b1;
        d    = 4'hF;
        step();
        chk("load_f", q, 4'hF);
        load = 1'b0;
        t    = 4'hF;
        #1;
        chk("tc_at_f", {3'b0, tc}, 4'h1);
        load = 1'b1;
        d    = 4'h9;
        #1;
        chk("tc_load_mask", {3'b0, tc}, 4'h0);
        step();
        chk("load_wins", q, 4'h9);
        chk("load_wins_qbar", q_bar, 4'h6);

        // Count 5 -> 6, then switch to toggle mode without clearing.
        d = 4'h5;
        step();
        load = 1'b0;
        t    = 4'b0001;
        step();
        chk("cnt_to_6", q, 4'h6);
        mode = MODE_TOGGLE;
        t    = 4'b0011;
        step();
        chk("mode_switch", q, 4'h5);

        // Reset mid-count discards the count; next edge resumes from reset value.
        mode = MODE_COUNT;
        t    = 4'b0001;
        step();
        chk("cnt_from_5", q, 4'h6);
        #2;
        rst = 1'b0;
        #1;
        chk("midcount_rst", q, 4'h0);
        rst = 1'b1;
        step();
        chk("resume_cnt", q, 4'h1);

`ifdef TFF_BANK_UPDOWN_EN
        // Down count from 1: 0 with tc, then wrap to F.
        dir = 1'b0;
        #1;
        chk("down_tc_at_1", {3'b0, tc}, 4'h0);
        step();
        chk("down_0", q, 4'h0);
        chk("down_tc_at_0", {3'b0, tc}, 4'h1);
        step();
        chk("down_wrap_f", q, 4'hF);
        step();
        chk("down_e", q, 4'hE);
        dir = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
